// File: rtl/sound_mixer_seq_pkg.sv
// sound_mixer_seq_pkg
//   Shared definitions for the time-multiplexed stereo sound mixer:
//   FSM state encoding, default filter parameters and a clog2 helper
//   that never returns less than 1 (so counters are at least one bit).
package sound_mixer_seq_pkg;

  localparam int DEF_FRAC_W    = 8;
  localparam int DEF_HPF_SHIFT = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_SCALE = 3'd2,
    S_HPF   = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sound_hpf.sv
// sound_hpf
//   One channel of the DC-blocking high-pass filter that models the
//   output coupling capacitor, followed by saturation to MIX_W.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (clears capacitor)
//     step     : update the capacitor state this cycle
//     en       : filter enabled; when low y = x and the capacitor clears
//     clr      : force the capacitor to 0 on this step
//     x        : signed input sample (MIX_W)
//     y        : signed, saturated output sample (MIX_W), combinational
module sound_hpf #(
  parameter int MIX_W     = 11,
  parameter int FRAC_W    = 8,
  parameter int HPF_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [MIX_W-1:0] x,
  output logic signed [MIX_W-1:0] y
);

  localparam int CAP_W = MIX_W + FRAC_W + 1;
  // One spare bit so differences and sums never overflow before clamping.
  localparam int WIDE  = CAP_W + 1;

  localparam logic signed [WIDE-1:0] SAT_MAX = {{(WIDE-MIX_W+1){1'b0}}, {(MIX_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] SAT_MIN = {{(WIDE-MIX_W+1){1'b1}}, {(MIX_W-1){1'b0}}};

  logic signed [CAP_W-1:0] cap_q, cap_d;
  logic signed [WIDE-1:0]  x_w, cap_w, x_sh, diff, cap_sum, y_w;

  always_comb begin
    x_w     = {{(WIDE-MIX_W){x[MIX_W-1]}}, x};
    cap_w   = {cap_q[CAP_W-1], cap_q};
    x_sh    = x_w <<< FRAC_W;
    diff    = x_sh - cap_w;
    cap_sum = cap_w + (diff >>> HPF_SHIFT);

    if (en) y_w = x_w - (cap_w >>> FRAC_W);
    else    y_w = x_w;

    if (clr || !en) cap_d = '0;
    else            cap_d = cap_sum[CAP_W-1:0];

    if (y_w > SAT_MAX)      y = SAT_MAX[MIX_W-1:0];
    else if (y_w < SAT_MIN) y = SAT_MIN[MIX_W-1:0];
    else                    y = y_w[MIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)       cap_q <= '0;
    else if (step) cap_q <= cap_d;
  end

endmodule

// File: rtl/sound_mixer_seq.sv
// sound_mixer_seq
//   Time-multiplexed stereo mixer. A sample_tick snapshots all channel
//   levels and routing controls, then channels are converted through a
//   bipolar DAC model and summed one per cycle, scaled by master volume,
//   passed through the capacitor high-pass model and presented as signed
//   stereo samples with a one-cycle valid pulse.
//   Ports:
//     clk, rst                : clock, synchronous active-high reset
//     sample_tick             : strobe that starts a mix (dropped while busy)
//     sound_enable, hpf_en    : master enable, high-pass enable
//     ch_level                : packed channel levels, LEVEL_W each
//     ch_dac_en               : per-channel DAC power
//     pan_left, pan_right     : per-channel routing
//     vol_left, vol_right     : master volume per side (gain = vol+1)
//     left, right             : signed output samples, held between valids
//     valid                   : one-cycle pulse when left/right update
//     busy                    : mix in progress
//     overrun                 : tick dropped this cycle
//     dbg_state               : current FSM state
//   Handshake: there is no back-pressure. A tick is accepted only in IDLE;
//   a tick in any other state is discarded and flagged on overrun in that
//   same cycle. valid is asserted for exactly one cycle, during which
//   left/right already hold the new sample.
module sound_mixer_seq
  import sound_mixer_seq_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LEVEL_W   = 4,
  parameter int VOL_W     = 3,
  parameter int OUT_W     = 16,
  parameter int HPF_SHIFT = DEF_HPF_SHIFT,
  parameter int FRAC_W    = DEF_FRAC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic                        sound_enable,
  input  logic                        hpf_en,
  input  logic [NUM_CH*LEVEL_W-1:0]   ch_level,
  input  logic [NUM_CH-1:0]           ch_dac_en,
  input  logic [NUM_CH-1:0]           pan_left,
  input  logic [NUM_CH-1:0]           pan_right,
  input  logic [VOL_W-1:0]            vol_left,
  input  logic [VOL_W-1:0]            vol_right,
  output logic signed [OUT_W-1:0]     left,
  output logic signed [OUT_W-1:0]     right,
  output logic                        valid,
  output logic                        busy,
  output logic                        overrun,
  output state_e                      dbg_state
);

  localparam int CW    = clog2_min1(NUM_CH);
  localparam int MIX_W = LEVEL_W + 2 + CW + VOL_W;
  localparam int ACC_W = LEVEL_W + 1 + CW;
  localparam int SH    = OUT_W - MIX_W;
  localparam int FULL  = (1 << LEVEL_W) - 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CH - 1);

  state_e                     state_q, state_d;
  logic [CW-1:0]              idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [MIX_W-1:0]    x_l_q, x_l_d, x_r_q, x_r_d;
  logic signed [OUT_W-1:0]    left_q, left_d, right_q, right_d;

  // Snapshot of everything that shapes one sample.
  logic [NUM_CH*LEVEL_W-1:0]  lvl_q, lvl_d;
  logic [NUM_CH-1:0]          dac_q, dac_d, pl_q, pl_d, pr_q, pr_d;
  logic [VOL_W-1:0]           vl_q, vl_d, vr_q, vr_d;
  logic                       snd_q, snd_d, hpf_q, hpf_d;

  logic [LEVEL_W-1:0]         lvl_cur;
  logic signed [ACC_W-1:0]    d_cur;
  logic signed [MIX_W-1:0]    acc_l_ext, acc_r_ext, gain_l, gain_r;
  logic signed [MIX_W-1:0]    y_l, y_r;
  logic signed [OUT_W-1:0]    y_l_ext, y_r_ext;
  logic                       hpf_step;

  // Bipolar DAC: level L maps to 2L - (2^LEVEL_W - 1); unpowered DAC gives 0.
  always_comb begin
    lvl_cur = lvl_q[int'(idx_q)*LEVEL_W +: LEVEL_W];
    if (dac_q[idx_q]) d_cur = $signed(ACC_W'({lvl_cur, 1'b0})) - $signed(ACC_W'(FULL));
    else              d_cur = '0;
  end

  always_comb begin
    acc_l_ext = {{(MIX_W-ACC_W){acc_l_q[ACC_W-1]}}, acc_l_q};
    acc_r_ext = {{(MIX_W-ACC_W){acc_r_q[ACC_W-1]}}, acc_r_q};
    gain_l    = MIX_W'(vl_q) + MIX_W'(1);
    gain_r    = MIX_W'(vr_q) + MIX_W'(1);
    y_l_ext   = OUT_W'(y_l);
    y_r_ext   = OUT_W'(y_r);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    x_l_d   = x_l_q;
    x_r_d   = x_r_q;
    left_d  = left_q;
    right_d = right_q;
    lvl_d   = lvl_q;
    dac_d   = dac_q;
    pl_d    = pl_q;
    pr_d    = pr_q;
    vl_d    = vl_q;
    vr_d    = vr_q;
    snd_d   = snd_q;
    hpf_d   = hpf_q;

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          lvl_d   = ch_level;
          dac_d   = ch_dac_en;
          pl_d    = pan_left;
          pr_d    = pan_right;
          vl_d    = vol_left;
          vr_d    = vol_right;
          snd_d   = sound_enable;
          hpf_d   = hpf_en;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (pl_q[idx_q]) acc_l_d = acc_l_q + d_cur;
        if (pr_q[idx_q]) acc_r_d = acc_r_q + d_cur;
        idx_d = idx_q + CW'(1);
        if (idx_q == LAST_IDX) state_d = S_SCALE;
      end
      S_SCALE: begin
        x_l_d   = acc_l_ext * gain_l;
        x_r_d   = acc_r_ext * gain_r;
        state_d = S_HPF;
      end
      S_HPF: begin
        // Saturated filter output, left-aligned into the output word.
        left_d  = snd_q ? (y_l_ext <<< SH) : '0;
        right_d = snd_q ? (y_r_ext <<< SH) : '0;
        state_d = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      x_l_q   <= '0;
      x_r_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      lvl_q   <= '0;
      dac_q   <= '0;
      pl_q    <= '0;
      pr_q    <= '0;
      vl_q    <= '0;
      vr_q    <= '0;
      snd_q   <= 1'b0;
      hpf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      x_l_q   <= x_l_d;
      x_r_q   <= x_r_d;
      left_q  <= left_d;
      right_q <= right_d;
      lvl_q   <= lvl_d;
      dac_q   <= dac_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      vl_q    <= vl_d;
      vr_q    <= vr_d;
      snd_q   <= snd_d;
      hpf_q   <= hpf_d;
    end
  end

  // Capacitors advance once per sample; a muted sample discharges them.
  assign hpf_step = (state_q == S_HPF);

  sound_hpf #(.MIX_W(MIX_W), .FRAC_W(FRAC_W), .HPF_SHIFT(HPF_SHIFT)) u_hpf_l (
    .clk (clk),
    .rst (rst),
    .step(hpf_step),
    .en  (hpf_q),
    .clr (!snd_q),
    .x   (x_l_q),
    .y   (y_l)
  );

  sound_hpf #(.MIX_W(MIX_W), .FRAC_W(FRAC_W), .HPF_SHIFT(HPF_SHIFT)) u_hpf_r (
    .clk (clk),
    .rst (rst),
    .step(hpf_step),
    .en  (hpf_q),
    .clr (!snd_q),
    .x   (x_r_q),
    .y   (y_r)
  );

  assign left      = left_q;
  assign right     = right_q;
  assign valid     = (state_q == S_OUT);
  assign busy      = (state_q == S_ACCUM) || (state_q == S_SCALE) || (state_q == S_HPF);
  assign overrun   = sample_tick && !rst && (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sound_mixer_seq.sv
module tb_sound_mixer_seq;
  import sound_mixer_seq_pkg::*;

  logic               clk;
  logic               rst;
  logic               sample_tick;
  logic               sound_enable;
  logic               hpf_en;
  logic [15:0]        ch_level;
  logic [3:0]         ch_dac_en;
  logic [3:0]         pan_left;
  logic [3:0]         pan_right;
  logic [2:0]         vol_left;
  logic [2:0]         vol_right;
  logic signed [15:0] left;
  logic signed [15:0] right;
  logic               valid;
  logic               busy;
  logic               overrun;
  state_e             dbg_state;

  int checks = 0;
  int errors = 0;

  sound_mixer_seq dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .sound_enable(sound_enable),
    .hpf_en      (hpf_en),
    .ch_level    (ch_level),
    .ch_dac_en   (ch_dac_en),
    .pan_left    (pan_left),
    .pan_right   (pan_right),
    .vol_left    (vol_left),
    .vol_right   (vol_right),
    .left        (left),
    .right       (right),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse one tick, then wait (bounded) for valid. lat is the number of
  // negedges after the tick cycle; -1 if valid never came.
  task automatic run_mix(output int lat);
    lat = -1;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) sample_tick = 1'b0;
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic set_cfg(input logic snd, input logic hpf, input logic [15:0] lvl,
                         input logic [3:0] dac, input logic [3:0] pl, input logic [3:0] pr,
                         input logic [2:0] vl, input logic [2:0] vr);
    sound_enable = snd;
    hpf_en       = hpf;
    ch_level     = lvl;
    ch_dac_en    = dac;
    pan_left     = pl;
    pan_right    = pr;
    vol_left     = vl;
    vol_right    = vr;
  endtask

  initial begin
    int lat;
    int prev;
    int ov_cnt;
    int val_cnt;
    int v_first;
    int v_second;
    int busy_seen;

    rst = 1'b1;
    sample_tick = 1'b0;
    set_cfg(1'b1, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_left", left, 0);
    check("rst_right", right, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", int'(dbg_state), int'(S_IDLE));

    // 1: single full-scale channel on the left, gain 8 -> 120 << 5
    set_cfg(1'b1, 1'b0, 16'h000F, 4'b0001, 4'b0001, 4'b0000, 3'd7, 3'd0);
    run_mix(lat);
    check("t1_latency", lat, 7);
    check("t1_left", left, 3840);
    check("t1_right", right, 0);

    // 2: all levels 0 -> each DAC gives -15, sum -60
    set_cfg(1'b1, 1'b0, 16'h0000, 4'b1111, 4'b1111, 4'b1111, 3'd0, 3'd0);
    run_mix(lat);
    check("t2_latency", lat, 7);
    check("t2_left_neg", left, -1920);
    check("t2_right_neg", right, -1920);
    ch_dac_en = 4'b0000;
    run_mix(lat);
    check("t2_left_dacoff", left, 0);
    check("t2_right_dacoff", right, 0);

    // Mixed levels: ch0=15(+15), ch1=8(+1), ch2=3(-9), ch3=0(-15)
    // left = ch0+ch1 = 16, gain 2 -> 32 -> 1024; right = ch2+ch3 = -24, gain 4 -> -96 -> -3072
    set_cfg(1'b1, 1'b0, 16'h038F, 4'b1111, 4'b0011, 4'b1100, 3'd1, 3'd3);
    run_mix(lat);
    check("mix_left", left, 1024);
    check("mix_right", right, -3072);

    // 3: high-pass with constant x=120 on the left
    set_cfg(1'b1, 1'b1, 16'h000F, 4'b0001, 4'b0001, 4'b0000, 3'd7, 3'd0);
    run_mix(lat);
    check("t3_y0", left, 3840);
    run_mix(lat);
    check("t3_y1", left, 3616);
    run_mix(lat);
    check("t3_y2", left, 3392);
    run_mix(lat);
    check("t3_y3", left, 3168);
    check("t3_right", right, 0);
    prev = int'(left);
    for (int i = 4; i < 200; i++) begin
      run_mix(lat);
      check("t3_nonincreasing", (int'(left) <= prev) ? 1 : 0, 1);
      prev = int'(left);
    end
    check("t3_settled", left, 32);

    // 5: muted sample gives zeros and discharges the capacitor
    sound_enable = 1'b0;
    run_mix(lat);
    check("t5_latency", lat, 7);
    check("t5_left_mute", left, 0);
    check("t5_right_mute", right, 0);
    sound_enable = 1'b1;
    run_mix(lat);
    check("t5_cap_cleared", left, 3840);

    // 4: overrun on a busy tick and on a tick during OUT; tick after OUT accepted
    hpf_en = 1'b0;
    ov_cnt = 0;
    val_cnt = 0;
    v_first = -1;
    v_second = -1;
    busy_seen = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      sample_tick = (k == 0) || (k == 3) || (k == 7) || (k == 8);
      #1;
      if (overrun === 1'b1) ov_cnt++;
      if (k == 1 && busy === 1'b1) busy_seen = 1;
      if (valid === 1'b1) begin
        val_cnt++;
        if (v_first < 0) v_first = k;
        else v_second = k;
      end
    end
    sample_tick = 1'b0;
    check("t4_overruns", ov_cnt, 2);
    check("t4_valids", val_cnt, 2);
    check("t4_first_valid", v_first, 7);
    check("t4_second_valid", v_second, 15);
    check("t4_busy", busy_seen, 1);

    // 6: reset during ACCUM aborts the mix
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_valid", valid, 0);
    check("t6_busy", busy, 0);
    check("t6_left", left, 0);
    check("t6_right", right, 0);
    check("t6_state", int'(dbg_state), int'(S_IDLE));
    val_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid === 1'b1) val_cnt++;
    end
    check("t6_no_valid", val_cnt, 0);

    // 6b: inputs changed after the snapshot do not affect the sample
    set_cfg(1'b1, 1'b0, 16'h000F, 4'b0001, 4'b0001, 4'b0000, 3'd7, 3'd0);
    @(negedge clk);
    sample_tick = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        sample_tick = 1'b0;
        ch_level = 16'h0000;
        vol_left = 3'd0;
        pan_right = 4'b1111;
        sound_enable = 1'b0;
      end
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("t6_snap_latency", lat, 7);
    check("t6_snap_left", left, 3840);
    check("t6_snap_right", right, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
